facelet_color_renderer: RTL

Stores the 54 facelet colour codes of the scanned cube (code 0=W, 1=O, 2=G, 3=Red, 4=Blue, 5=Y) and, on request, streams them back out as 24-bit RGB pixels in facelet order. This is the code-to-RGB direction of the colour-classification path. It feeds the on-screen cube preview / LED driver through a valid/ready handshake. Writes arrive one facelet at a time from the scan sequencer.

---
 rtl/facelet_color_renderer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/facelet_color_renderer.sv
// facelet_color_renderer
//
// Holds the 54 facelet colour codes of the scanned cube (0=W, 1=O, 2=G,
// 3=Red, 4=Blue, 5=Y) and, on request, streams them back out as 24-bit RGB
// pixels in facelet order over a valid/ready handshake.
//
// Optional feature macro: FACELET_BAD_CODE_EN
//   defined   : codes 6/7 render magenta (FF00FF) and raise the sticky bad_code
//   undefined : codes 6/7 render black and bad_code is tied low
//
// Ports
//   clock      : sole clock, posedge
//   reset_n    : asynchronous active-low reset
//   wr_en      : write strobe (accepted in every state)
//   wr_addr    : facelet index to write; indices >= NUM_FACELETS are ignored
//   wr_color   : 3-bit colour code to store
//   start      : request one full readout pass (ignored while busy)
//   busy       : pass in progress (STREAM or DONE)
//   out_valid  : pixel available
//   out_ready  : sink accepts pixel
//   out_rgb    : {R,G,B}, 8 bits per channel
//   out_index  : facelet index of the presented pixel
//   out_last   : presented pixel is the final facelet
//   done       : one-cycle pulse after the last transfer
//   bad_code   : sticky invalid-code flag
module facelet_color_renderer #(
    parameter int unsigned NUM_FACELETS = 54,
    parameter int unsigned ADDR_W       = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_color,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_rgb,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              done,
    output logic              bad_code
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_FACELETS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                  state;
    logic [2:0]              mem [NUM_FACELETS];
    logic [NUM_FACELETS-1:0] written;

    logic                    wr_hit;
    logic                    xfer;
    logic                    load_en;
    logic [ADDR_W-1:0]       load_idx;

    function automatic logic [23:0] code_to_rgb(input logic [2:0] code,
                                                input logic       valid_entry);
        logic [23:0] rgb;
        rgb = '0;
        if (valid_entry) begin
            case (code)
                3'd0:    rgb = 24'hFFFFFF;
                3'd1:    rgb = 24'hFF8000;
                3'd2:    rgb = 24'h00FF00;
                3'd3:    rgb = 24'hFF0000;
                3'd4:    rgb = 24'h0000FF;
                3'd5:    rgb = 24'hFFFF00;
`ifdef FACELET_BAD_CODE_EN
                default: rgb = 24'hFF00FF;
`else
                default: rgb = '0;
`endif
            endcase
        end
        return rgb;
    endfunction

    assign wr_hit = wr_en && (32'(wr_addr) < NUM_FACELETS);
    assign xfer   = out_valid && out_ready;

    // The output register is loaded either by an accepted start (entry 0)
    // or by a non-final handshake (next entry), which keeps one pixel per
    // cycle under continuous ready.
    always_comb begin
        load_en  = 1'b0;
        load_idx = '0;
        if (state == IDLE && start) begin
            load_en  = 1'b1;
            load_idx = '0;
        end else if (state == STREAM && xfer && !out_last) begin
            load_en  = 1'b1;
            load_idx = out_index + ADDR_W'(1);
        end
    end

    // Storage is not reset; validity of each entry lives in 'written'.
    always_ff @(posedge clock) begin
        if (wr_hit)
            mem[wr_addr] <= wr_color;
    end

    // Reads of mem/written below see pre-write values, so a same-cycle write
    // to the entry being loaded shows the old contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            written   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (wr_hit)
                written[wr_addr] <= 1'b1;

            if (load_en) begin
                out_rgb   <= code_to_rgb(mem[load_idx], written[load_idx]);
                out_index <= load_idx;
                out_last  <= (load_idx == LAST_IDX);
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer && out_last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FACELET_BAD_CODE_EN
    // Tracks whether the presented pixel came from a written code 6/7, so the
    // flag can be raised on that pixel's handshake rather than at load time.
    logic pix_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_bad  <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            if (load_en)
                pix_bad <= written[load_idx] && (mem[load_idx][2:1] == 2'b11);
            if (state == IDLE && start)
                bad_code <= 1'b0;
            else if (xfer && pix_bad)
                bad_code <= 1'b1;
        end
    end
`else
    assign bad_code = 1'b0;
`endif

endmodule
